// File: rtl/uart_alu_sequencer.sv
// Collects A, B, opcode bytes from uart_rx, runs them through the ALU and hands the result to uart_tx.
// Optional inter-byte timeout is enabled by defining UART_ALU_SEQ_TIMEOUT_EN.
module uart_alu_sequencer #(
  parameter int N              = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] i_rx_data,
  input  logic         i_rx_valid,
  input  logic [N-1:0] i_alu_result,
  input  logic         i_tx_done,
  output logic [N-1:0] o_A,
  output logic [N-1:0] o_B,
  output logic [N-1:0] o_op,
  output logic [N-1:0] o_tx_data,
  output logic         o_tx_start,
  output logic         o_busy,
  output logic         o_timeout,
  output logic         o_overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GOT_A,
    S_GOT_B,
    S_EXEC,
    S_TX_WAIT
  } state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_alu_sequencer: TIMEOUT_CYCLES must be at least 2");
  end

  state_t       r_state;
  logic [N-1:0] r_A;
  logic [N-1:0] r_B;
  logic [N-1:0] r_op;
  logic [N-1:0] r_tx_data;
  logic         r_tx_start;
  logic         r_overrun;

`ifdef UART_ALU_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          r_timeout;
  logic          w_expire;

  // Expiry fires on the edge where the counter would reach TIMEOUT_CYCLES-1.
  assign w_expire  = (r_cnt == CW'(TIMEOUT_CYCLES - 2));
  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_A        <= '0;
      r_B        <= '0;
      r_op       <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_overrun  <= 1'b0;
`ifdef UART_ALU_SEQ_TIMEOUT_EN
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_tx_start <= 1'b0;
`ifdef UART_ALU_SEQ_TIMEOUT_EN
      r_timeout  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (i_rx_valid) begin
            r_A     <= i_rx_data;
            r_state <= S_GOT_A;
          end
`ifdef UART_ALU_SEQ_TIMEOUT_EN
          r_cnt <= '0;
`endif
        end
        S_GOT_A: begin
          if (i_rx_valid) begin
            r_B     <= i_rx_data;
            r_state <= S_GOT_B;
`ifdef UART_ALU_SEQ_TIMEOUT_EN
            r_cnt   <= '0;
          end else if (w_expire) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
`endif
          end
        end
        S_GOT_B: begin
          if (i_rx_valid) begin
            r_op    <= i_rx_data;
            r_state <= S_EXEC;
`ifdef UART_ALU_SEQ_TIMEOUT_EN
            r_cnt   <= '0;
          end else if (w_expire) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
`endif
          end
        end
        S_EXEC: begin
          // ALU inputs have been stable for a full cycle by now.
          r_tx_data  <= i_alu_result;
          r_tx_start <= 1'b1;
          r_state    <= S_TX_WAIT;
          if (i_rx_valid) r_overrun <= 1'b1;
        end
        S_TX_WAIT: begin
          if (i_tx_done) r_state <= S_IDLE;
          if (i_rx_valid) r_overrun <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_A        = r_A;
  assign o_B        = r_B;
  assign o_op       = r_op;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_overrun  = r_overrun;
  assign o_busy     = (r_state != S_IDLE);

endmodule
